tart_vis_stream: RTL and testbench

- Sequencer that drains one completed visibility block from the correlator bank (tart_dsp read-back port) each time a bank switch signals `newblock`.
- Issues classic single-outstanding Wishbone reads word by word and forwards each word to a valid/ready sink (the SPI read-back path).
- Keeps a running checksum and block count, pulses `streamed_o` at block end, and flags blocks lost to overrun.
- Sits between tart_dsp (slave) and the SPI/register layer (sink), replacing ad-hoc host-driven read loops.

---
 rtl/tart_vis_stream.sv | 118 +++++++++++
 tb/tb_tart_vis_stream.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tart_vis_stream.sv
// tart_vis_stream: drains one visibility block per bank switch over
// Wishbone reads into a valid/ready sink, with checksum and block count.
module tart_vis_stream #(
  parameter int WIDTH = 8,
  parameter int ABITS = 12,
  parameter int COUNT = 24,
  parameter int BBITS = 4,
  parameter int CBITS = 24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             newblock_i,
  input  logic             clr_i,
  output logic             vx_cyc_o,
  output logic             vx_stb_o,
  output logic             vx_we_o,
  output logic [ABITS-1:0] vx_adr_o,
  output logic [BBITS-1:0] vx_blk_o,
  input  logic             vx_ack_i,
  input  logic [WIDTH-1:0] vx_dat_i,
  output logic [WIDTH-1:0] dat_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             streamed_o,
  output logic [CBITS-1:0] checksum_o,
  output logic             overrun_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    PUSH,
    DONE
  } state_t;

  localparam logic [ABITS-1:0] LAST = ABITS'(COUNT - 1);

  state_t           state;
  logic             pending;
  logic [CBITS-1:0] sum;
  logic             nb;
  logic             start;

  assign nb      = en_i & newblock_i;
  assign start   = (state == IDLE) & en_i & (newblock_i | pending);
  assign vx_we_o = 1'b0;
  assign busy_o  = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= IDLE;
      pending    <= 1'b0;
      sum        <= '0;
      vx_cyc_o   <= 1'b0;
      vx_stb_o   <= 1'b0;
      vx_adr_o   <= '0;
      vx_blk_o   <= '0;
      dat_o      <= '0;
      valid_o    <= 1'b0;
      streamed_o <= 1'b0;
      checksum_o <= '0;
      overrun_o  <= 1'b0;
    end else begin
      streamed_o <= 1'b0;
      if (clr_i) overrun_o <= 1'b0;
      // one block may queue behind the running one; more are lost
      if (state != IDLE && nb) begin
        if (pending) overrun_o <= 1'b1;
        else         pending   <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= REQ;
            vx_adr_o <= '0;
            sum      <= '0;
            pending  <= pending & newblock_i;
            vx_cyc_o <= 1'b1;
            vx_stb_o <= 1'b1;
          end
        end
        REQ: begin
          if (vx_ack_i) begin
            vx_cyc_o <= 1'b0;
            vx_stb_o <= 1'b0;
            dat_o    <= vx_dat_i;
            valid_o  <= 1'b1;
            sum      <= sum + CBITS'(vx_dat_i);
            state    <= PUSH;
          end
        end
        PUSH: begin
          if (valid_o && ready_i) begin
            valid_o <= 1'b0;
            if (vx_adr_o == LAST) begin
              state      <= DONE;
              streamed_o <= 1'b1;
            end else begin
              vx_adr_o <= vx_adr_o + 1'b1;
              vx_cyc_o <= 1'b1;
              vx_stb_o <= 1'b1;
              state    <= REQ;
            end
          end
        end
        DONE: begin
          checksum_o <= sum;
          vx_blk_o   <= vx_blk_o + 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tart_vis_stream.sv
// tb_tart_vis_stream: random slave/sink traffic scored against a
// word-queue and running-sum model of the block stream.
module tb_tart_vis_stream;

  localparam int COUNT = 24;

  logic        clk_i = 1'b0;
  logic        rst_ni, en_i, newblock_i, clr_i;
  logic        vx_ack_i, ready_i;
  logic [7:0]  vx_dat_i;
  logic        vx_cyc_o, vx_stb_o, vx_we_o;
  logic [11:0] vx_adr_o;
  logic [3:0]  vx_blk_o;
  logic [7:0]  dat_o;
  logic        valid_o, busy_o, streamed_o, overrun_o;
  logic [23:0] checksum_o;

  logic        cyc8, stb8, we8, valid8, busy8, str8, ovr8;
  logic [11:0] adr8;
  logic [3:0]  blk8;
  logic [7:0]  dat8;
  logic [7:0]  csum8;

  always #5 clk_i = ~clk_i;

  tart_vis_stream u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
    .newblock_i(newblock_i), .clr_i(clr_i),
    .vx_cyc_o(vx_cyc_o), .vx_stb_o(vx_stb_o), .vx_we_o(vx_we_o),
    .vx_adr_o(vx_adr_o), .vx_blk_o(vx_blk_o),
    .vx_ack_i(vx_ack_i), .vx_dat_i(vx_dat_i),
    .dat_o(dat_o), .valid_o(valid_o), .ready_i(ready_i),
    .busy_o(busy_o), .streamed_o(streamed_o),
    .checksum_o(checksum_o), .overrun_o(overrun_o)
  );

  tart_vis_stream #(.CBITS(8)) u_dut8 (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
    .newblock_i(newblock_i), .clr_i(clr_i),
    .vx_cyc_o(cyc8), .vx_stb_o(stb8), .vx_we_o(we8),
    .vx_adr_o(adr8), .vx_blk_o(blk8),
    .vx_ack_i(vx_ack_i), .vx_dat_i(vx_dat_i),
    .dat_o(dat8), .valid_o(valid8), .ready_i(ready_i),
    .busy_o(busy8), .streamed_o(str8),
    .checksum_o(csum8), .overrun_o(ovr8)
  );

  int ntot = 0;
  int nbad = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    ntot++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic [7:0]  q[$];
  int          nword, sidx, stallc, blocks_done, waitc, ackdel;
  int unsigned sum, done_sum;
  bit          mon_on, chk_next, held_v, prev_str;
  logic [7:0]  held_d;
  int          data_mode, rdy_mode;
  bit          ack_rand;

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic pulse();
    newblock_i = 1'b1;
    tick();
    newblock_i = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int b = 0;
    while (blocks_done < n && b < 4000) begin
      tick();
      b++;
    end
    if (blocks_done < n) check("timeout", blocks_done, n);
  endtask

  task automatic clear_model();
    q.delete();
    nword = 0; sidx = 0; stallc = 0; sum = 0; done_sum = 0;
    blocks_done = 0; chk_next = 0; waitc = 0; held_v = 0;
    prev_str = 0; ackdel = 1;
  endtask

  task automatic do_reset();
    mon_on = 0;
    rst_ni = 1'b0;
    tick();
    tick();
    clear_model();
    rst_ni = 1'b1;
    mon_on = 1;
    tick();
  endtask

  // slave, sink and scoreboard, all at the falling edge
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk_i);
      if (!mon_on) begin
        vx_ack_i = 1'b0;
        ready_i  = 1'b1;
        held_v   = 0;
        continue;
      end
      if (chk_next) begin
        chk_next = 0;
        check("csum", checksum_o, done_sum & 32'hFF_FFFF);
        check("csum8", csum8, done_sum & 32'hFF);
        check("blk", vx_blk_o, blocks_done % 16);
      end
      case (rdy_mode)
        1: begin
          if (valid_o && sidx == 3 && stallc < 5) begin
            ready_i = 1'b0;
            stallc++;
          end else ready_i = 1'b1;
        end
        2: ready_i = ($urandom_range(0, 3) != 0);
        default: ready_i = 1'b1;
      endcase
      if (held_v) begin
        check("hold_v", valid_o, 1);
        check("hold_d", dat_o, held_d);
      end
      held_v = 0;
      if (valid_o) begin
        check("no_stb", vx_stb_o, 0);
        if (ready_i) begin
          check("qsz", q.size() > 0, 1);
          if (q.size() > 0) check("data", dat_o, q.pop_front());
          sidx++;
        end else begin
          held_v = 1;
          held_d = dat_o;
        end
      end
      vx_ack_i = 1'b0;
      if (vx_cyc_o && vx_stb_o) begin
        if (waitc >= ackdel) begin
          case (data_mode)
            0: d = 8'(nword + 1);
            1: d = 8'hFF;
            default: d = 8'($urandom_range(0, 255));
          endcase
          vx_ack_i = 1'b1;
          vx_dat_i = d;
          check("adr", vx_adr_o, nword);
          q.push_back(d);
          nword++;
          sum += d;
          waitc = 0;
          ackdel = ack_rand ? $urandom_range(0, 3) : 1;
        end else waitc++;
      end
      if (streamed_o) begin
        check("str_once", prev_str, 0);
        check("nword", nword, COUNT);
        check("sidx", sidx, COUNT);
        done_sum = sum;
        sum = 0; nword = 0; sidx = 0; stallc = 0;
        blocks_done++;
        chk_next = 1;
      end
      prev_str = streamed_o;
    end
  end

  initial begin
    rst_ni = 1'b0; en_i = 1'b0; newblock_i = 1'b0; clr_i = 1'b0;
    vx_ack_i = 1'b0; vx_dat_i = 8'h00; ready_i = 1'b1;
    data_mode = 0; rdy_mode = 0; ack_rand = 0;
    clear_model();
    mon_on = 0;
    repeat (3) tick();
    check("rst_cyc", vx_cyc_o, 0);
    check("rst_stb", vx_stb_o, 0);
    check("rst_we", vx_we_o, 0);
    check("rst_adr", vx_adr_o, 0);
    check("rst_blk", vx_blk_o, 0);
    check("rst_val", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_csum", checksum_o, 0);
    check("rst_ovr", overrun_o, 0);
    rst_ni = 1'b1;
    mon_on = 1;
    en_i = 1'b1;
    tick();

    // sequential data, ack on second strobe cycle
    pulse();
    wait_done(1);
    tick();
    check("seq_csum", checksum_o, 24'h12C);
    check("seq_blk", vx_blk_o, 1);
    repeat (3) tick();
    check("seq_idle", busy_o, 0);

    // sink stall on word 3
    rdy_mode = 1;
    pulse();
    wait_done(2);
    tick();
    check("stall_csum", checksum_o, 24'h12C);
    rdy_mode = 2; data_mode = 2; ack_rand = 1;

    // queued block, then overrun and clear
    pulse();
    repeat (10) tick();
    pulse();
    check("ovr_0", overrun_o, 0);
    wait_done(3);
    tick();
    check("pend_idle", busy_o, 0);
    tick();
    check("pend_start", vx_cyc_o, 1);
    pulse();
    repeat (5) tick();
    pulse();
    check("ovr_1", overrun_o, 1);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    check("ovr_clr", overrun_o, 0);
    wait_done(5);
    check("ovr_stay", overrun_o, 0);

    // en drops mid-block with one queued
    pulse();
    repeat (5) tick();
    pulse();
    en_i = 1'b0;
    wait_done(6);
    repeat (10) tick();
    check("en_wait", busy_o, 0);
    en_i = 1'b1;
    tick();
    check("en_resume", busy_o, 1);
    wait_done(7);
    repeat (3) tick();

    // newblock ignored while disabled
    en_i = 1'b0;
    pulse();
    repeat (5) tick();
    check("dis_busy", busy_o, 0);
    check("dis_ovr", overrun_o, 0);
    en_i = 1'b1;

    // reset in the middle of a request
    data_mode = 0; ack_rand = 0; rdy_mode = 0;
    pulse();
    begin
      int b = 0;
      while (!(vx_cyc_o && vx_adr_o == 12'd5) && b < 500) begin
        tick();
        b++;
      end
    end
    check("at5", vx_adr_o, 5);
    mon_on = 0;
    rst_ni = 1'b0;
    tick();
    check("mr_cyc", vx_cyc_o, 0);
    check("mr_stb", vx_stb_o, 0);
    check("mr_val", valid_o, 0);
    check("mr_adr", vx_adr_o, 0);
    check("mr_blk", vx_blk_o, 0);
    tick();
    clear_model();
    rst_ni = 1'b1;
    mon_on = 1;
    tick();
    pulse();
    wait_done(1);
    tick();
    check("mr_csum", checksum_o, 24'h12C);

    // all-ones words, 17 blocks for the counter wrap
    do_reset();
    data_mode = 1; ack_rand = 1; rdy_mode = 2;
    for (int k = 0; k < 17; k++) begin
      pulse();
      wait_done(k + 1);
      tick();
    end
    check("wrap_blk", vx_blk_o, 1);
    check("wrap_csum8", csum8, 8'hE8);
    check("wrap_csum", checksum_o, 24'h17E8);

    // random traffic
    data_mode = 2;
    for (int k = 0; k < 3; k++) begin
      pulse();
      wait_done(18 + k);
      tick();
    end

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule
